// File: rtl/proc_datapath.sv
// Processor datapath: PC, IR, R0-R3, A/G, add/sub ALU, display register and a shared memory port.
// Optional macro DP_FLAGS_EN adds zero/carry/overflow flags that are registered on each Gin edge.
module proc_datapath #(
   parameter int unsigned DW = 16,
   parameter int unsigned AW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          _Extern,
   input  logic          Gout,
   input  logic          Ain,
   input  logic          Gin,
   input  logic          DPin,
   input  logic          RdX,
   input  logic          RdY,
   input  logic          WrX,
   input  logic          add_sub,
   input  logic          pc_en,
   input  logic          ILin,
   input  logic          rf_sel,
   input  logic          sw_sel,
   input  logic          MemWr,
   input  logic          AddrSel,
   input  logic [DW-1:0] mem_rdata,
   output logic [3:0]    operation,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   output logic [DW-1:0] disp_out,
   output logic [AW-1:0] pc_out
`ifdef DP_FLAGS_EN
   ,
   output logic          flag_z,
   output logic          flag_c,
   output logic          flag_v
`endif
);

   logic [AW-1:0] pc_q;
   logic [DW-1:0] ir_q;
   logic [DW-1:0] a_q;
   logic [DW-1:0] g_q;
   logic [DW-1:0] disp_q;
   logic [DW-1:0] r_q [4];

   logic [1:0]    x;
   logic [1:0]    y;
   logic [DW-1:0] imm;
   logic [DW-1:0] rd_port;
   logic [DW-1:0] b_op;
   logic [DW-1:0] alu_res;
   logic [DW-1:0] wr_data;

   assign x   = ir_q[11:10];
   assign y   = ir_q[9:8];
   assign imm = {{(DW-8){1'b0}}, ir_q[7:0]};

   always_comb begin
      rd_port = '0;
      if (RdX) begin
         rd_port = r_q[x];
      end else if (RdY) begin
         rd_port = r_q[y];
      end
   end

   always_comb begin
      b_op = '0;
      if (rf_sel) begin
         b_op = rd_port;
      end else if (sw_sel) begin
         b_op = imm;
      end
   end

`ifdef DP_FLAGS_EN
   // Subtract as A + ~B + 1 so the top bit is the no-borrow indication.
   logic [DW:0] alu_wide;
   logic        ovf;

   always_comb begin
      if (add_sub) begin
         alu_wide = {1'b0, a_q} + {1'b0, ~b_op} + (DW+1)'(1);
      end else begin
         alu_wide = {1'b0, a_q} + {1'b0, b_op};
      end
   end

   assign alu_res = alu_wide[DW-1:0];

   always_comb begin
      if (add_sub) begin
         ovf = (a_q[DW-1] != b_op[DW-1]) && (alu_res[DW-1] != a_q[DW-1]);
      end else begin
         ovf = (a_q[DW-1] == b_op[DW-1]) && (alu_res[DW-1] != a_q[DW-1]);
      end
   end
`else
   assign alu_res = add_sub ? (a_q - b_op) : (a_q + b_op);
`endif

   always_comb begin
      wr_data = '0;
      if (_Extern) begin
         wr_data = mem_rdata;
      end else if (Gout) begin
         wr_data = g_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q   <= '0;
         ir_q   <= '0;
         a_q    <= '0;
         g_q    <= '0;
         disp_q <= '0;
         for (int i = 0; i < 4; i++) begin
            r_q[i] <= '0;
         end
`ifdef DP_FLAGS_EN
         flag_z <= 1'b0;
         flag_c <= 1'b0;
         flag_v <= 1'b0;
`endif
      end else begin
         if (Ain) a_q <= rd_port;
         if (Gin) g_q <= alu_res;
         if (DPin) disp_q <= rd_port;
         if (WrX) r_q[x] <= wr_data;
         if (ILin) ir_q <= mem_rdata;
         if (pc_en) pc_q <= pc_q + 1'b1;
`ifdef DP_FLAGS_EN
         if (Gin) begin
            flag_z <= (alu_res == '0);
            flag_c <= alu_wide[DW];
            flag_v <= ovf;
         end
`endif
      end
   end

   assign operation = ir_q[15:12];
   assign mem_addr  = AddrSel ? r_q[y][AW-1:0] : pc_q;
   assign mem_wdata = r_q[x];
   assign mem_we    = MemWr;
   assign disp_out  = disp_q;
   assign pc_out    = pc_q;

endmodule

// File: doc/proc_datapath.md
Name: proc_datapath

Overview:
- Fetch/execute datapath driven cycle-by-cycle by the processor control FSM.
- Holds the PC, the instruction register (IR), four general registers R0-R3, the A and G registers, the add/sub unit and the display register.
- Supplies the opcode back to the FSM and drives the single shared instruction/data memory port.
- Memory read is combinational: mem_rdata is valid in the same cycle as mem_addr.

Parameters:
DW, 16, data/register width
AW, 8, PC and memory address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
_Extern  in  1  register write source: 1 = mem_rdata, 0 = G
Gout  in  1  enable G as write source
Ain  in  1  load A from read port
Gin  in  1  load G from ALU result
DPin  in  1  load display register from read port
RdX  in  1  read port selects R[X]
RdY  in  1  read port selects R[Y]
WrX  in  1  write R[X]
add_sub  in  1  0 = add, 1 = subtract
pc_en  in  1  increment PC
ILin  in  1  load IR from mem_rdata
rf_sel  in  1  ALU B operand = read port
sw_sel  in  1  ALU B operand = immediate
MemWr  in  1  memory write strobe
AddrSel  in  1  address source: 0 = PC, 1 = R[Y]
mem_rdata  in  DW  memory read data
operation  out  4  IR[15:12], to FSM
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_we  out  1  memory write enable
disp_out  out  DW  display register
pc_out  out  AW  current PC

Behaviour:
- Reset: when reset is low, PC, IR, R0-R3, A, G and the display register clear to 0 immediately, independent of clk. This applies at any point, including mid-instruction.
- Reset consequences: operation = 0, disp_out = 0, pc_out = 0.
- IR fields:
  - opcode = IR[15:12]
  - X = IR[11:10]
  - Y = IR[9:8]
  - imm = IR[7:0], zero-extended to DW
- Read port (combinational): RdX ? R[X] : RdY ? R[Y] : 0. RdX has priority when both are set.
- ALU B operand: rf_sel ? read port : sw_sel ? imm : 0. rf_sel has priority.
- ALU result: add_sub ? A - B : A + B, modulo 2^DW. Carry and borrow are discarded unless DP_FLAGS_EN is defined.
- Register updates on the rising clk edge:
  - Ain: A <= read port
  - Gin: G <= ALU result
  - DPin: display <= read port
  - WrX: R[X] <= _Extern ? mem_rdata : (Gout ? G : 0)
  - ILin: IR <= mem_rdata
  - pc_en: PC <= PC + 1, wrapping from 2^AW - 1 to 0
- Independent enables: all enables act independently. Simultaneous assertions all take effect in the same edge.
- Read/write in the same cycle: a read of R[X] during a write of R[X] returns the old value, and the new value is visible the next cycle.
- FETCH case: pc_en and ILin in the same cycle load IR from the pre-increment PC address.
- Memory interface (combinational):
  - mem_addr = AddrSel ? R[Y][AW-1:0] : PC
  - mem_wdata = R[X]
  - mem_we = MemWr
- Instruction latency:
  - MV: R[X] <= R[Y] via READ_Y (A <= R[Y]), MV (G <= A + 0), WRITE_X. R[X] is updated 3 cycles after decode.
  - ADD, SUB, ADDI, SUBI: same 3-cycle shape.
  - LOAD and STORE: complete in 1 cycle.
  - DISP: disp_out updates on the edge ending the DISP cycle.
- operation changes only on an ILin edge or on reset.

Optional Feature:
- Macro: DP_FLAGS_EN.
- With the macro defined:
  - Adds outputs flag_z, flag_c and flag_v, all reset to 0.
  - All three update only on a Gin edge, from the ALU result: zero, carry-out (add) or no-borrow (sub), and signed overflow.
- Without the macro: the ports are absent and no flag logic is generated.

Test Plan:
- Reset: drive reset low mid-run with R1 = 0x1234 -> all registers, disp_out and pc_out read 0 while reset is low. The first fetch after release uses mem_addr = 0.
- Fetch: memory[0] = 0x0C00, pc_en = ILin = 1 for one cycle -> operation = 0x0, pc_out = 1, mem_addr = 0 during that cycle.
- Add: R1 = 0x0005, R2 = 0x0003, X = 1, Y = 2.
  - Sequence READ_Y, ADD, WRITE_X -> R1 = 0x0008.
  - Repeat with SUB (READ_X, SUB, WRITE_X) -> R1 = 0x0005.
- Immediate with wrap: R0 = 0xFFFF, ADDI with imm = 0x02 -> R0 = 0x0001.
  - With DP_FLAGS_EN defined: flag_c = 1, flag_z = 0.
- Load/store: R3 = 0x0040, X = 0, Y = 3.
  - STORE -> mem_we = 1, mem_addr = 0x40, mem_wdata = R0.
  - LOAD with mem_rdata = 0xBEEF -> R0 = 0xBEEF.
- PC wrap and display: PC = 0xFF with pc_en -> pc_out = 0x00. DISP with R[X] = 0x00A5 -> disp_out = 0x00A5.
